// File: rtl/pillar_pkg.sv
// Shared definitions for the pipeline stage sequencer.
//   ST_*          default stage indices (FETCH..WRITEBACK)
//   WAIT_CNT_W    width of the memory wait (timeout) down-counter
//   seq_state_t   sequencer FSM state encoding
package pillar_pkg;

    localparam int ST_FETCH   = 0;
    localparam int ST_DECODE  = 1;
    localparam int ST_EXEC    = 2;
    localparam int ST_MEM     = 3;
    localparam int ST_WB      = 4;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        SEQ_RUN    = 2'd0,
        SEQ_WAIT   = 2'd1,
        SEQ_HALTED = 2'd2,
        SEQ_FAULT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/stage_next_sel.sv
// Next-stage priority search.
// Returns the lowest stage index above the current one whose skip bit is
// clear. Stages 0 and 1 are never skipped; the last stage (WRITEBACK) is the
// fallback when every intermediate stage is masked.
//   stage       in   current stage index
//   skip_mask   in   per-stage skip request from decode
//   next_stage  out  stage to enter on advance
module stage_next_sel
    import pillar_pkg::*;
#(
    parameter int NSTAGES = ST_WB + 1,
    parameter int STAGE_W = 3
) (
    input  logic [STAGE_W-1:0] stage,
    input  logic [NSTAGES-1:0] skip_mask,
    output logic [STAGE_W-1:0] next_stage
);

    // Bits 0/1 and the WRITEBACK bit have no effect on the search.
    logic unused_mask_bits;
    assign unused_mask_bits = ^{skip_mask[1:0], skip_mask[NSTAGES-1]};

    always_comb begin
        next_stage = STAGE_W'(NSTAGES - 1);
        // Walk downwards so the lowest eligible index wins.
        for (int s = NSTAGES - 2; s >= 2; s--) begin
            if (s > int'(stage) && !skip_mask[s]) begin
                next_stage = STAGE_W'(s);
            end
        end
        if (stage == '0) begin
            next_stage = STAGE_W'(1);
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer.
// Steps FETCH..WRITEBACK one stage per cycle, skipping stages selected by
// decode, waiting on a req/ack memory at the fetch and memory stages, with
// halt at instruction boundaries, stall, and a sticky memory-timeout fault.
//   clk, reset      clock / async active-high reset
//   skip_mask_i     per-stage skip request (sampled on advance)
//   mem_use_i       instruction accesses memory in the memory stage
//   mem_ack_i       memory completes the outstanding request
//   stall_i         hold current stage and state
//   halt_i          stop at next WRITEBACK;  resume_i  leave HALTED
//   stage_o         current stage index;  stage_en_o  one-hot of it
//   mem_req_o       memory request, held until ack
//   pc_readin_o     PC advance strobe;  retire_o  same cycle
//   ir_load_o       IR capture strobe (fetch ack cycle)
//   instret_o       retired-instruction count
//   halted_o        in HALTED;  fault_o  sticky timeout fault
//
// state      | meaning
// -----------+----------------------------------------------------------
// SEQ_RUN    | advancing one stage per cycle (issues req at fetch/mem)
// SEQ_WAIT   | memory request outstanding, waiting for ack
// SEQ_HALTED | parked at an instruction boundary until resume_i
// SEQ_FAULT  | memory timed out; left only by reset
module stage_sequencer
    import pillar_pkg::*;
#(
    parameter int NSTAGES   = ST_WB + 1,
    parameter int STAGE_W   = 3,
    parameter int FETCH_IDX = ST_FETCH,
    parameter int MEM_IDX   = ST_MEM,
    parameter int TIMEOUT   = 15,
    parameter int CNT_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NSTAGES-1:0] skip_mask_i,
    input  logic               mem_use_i,
    input  logic               mem_ack_i,
    input  logic               stall_i,
    input  logic               halt_i,
    input  logic               resume_i,
    output logic [STAGE_W-1:0] stage_o,
    output logic [NSTAGES-1:0] stage_en_o,
    output logic               mem_req_o,
    output logic               pc_readin_o,
    output logic               ir_load_o,
    output logic               retire_o,
    output logic [CNT_W-1:0]   instret_o,
    output logic               halted_o,
    output logic               fault_o
);

    localparam logic [STAGE_W-1:0]    FETCH_ST     = STAGE_W'(FETCH_IDX);
    localparam logic [STAGE_W-1:0]    MEM_ST       = STAGE_W'(MEM_IDX);
    localparam logic [STAGE_W-1:0]    WB_ST        = STAGE_W'(NSTAGES - 1);
    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LOAD = WAIT_CNT_W'(TIMEOUT - 1);

    seq_state_t            state_q, state_d;
    logic [STAGE_W-1:0]    stage_q, stage_d, stage_adv;
    logic [WAIT_CNT_W-1:0] wcnt_q, wcnt_d;
    logic                  ack_held_q, ack_held_d;
    logic                  halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0]      instret_q;
    logic                  req_c, pc_c, ir_c;
    logic                  at_fetch, at_mem, at_wb;

    stage_next_sel #(
        .NSTAGES (NSTAGES),
        .STAGE_W (STAGE_W)
    ) u_next_sel (
        .stage      (stage_q),
        .skip_mask  (skip_mask_i),
        .next_stage (stage_adv)
    );

    assign at_fetch = (stage_q == FETCH_ST);
    assign at_mem   = (stage_q == MEM_ST);
    assign at_wb    = (stage_q == WB_ST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SEQ_RUN;
            stage_q     <= FETCH_ST;
            wcnt_q      <= '0;
            ack_held_q  <= 1'b0;
            halt_pend_q <= 1'b0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            wcnt_q      <= wcnt_d;
            ack_held_q  <= ack_held_d;
            halt_pend_q <= halt_pend_d;
            if (pc_c) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        wcnt_d      = wcnt_q;
        ack_held_d  = ack_held_q;
        halt_pend_d = halt_pend_q;
        req_c       = 1'b0;
        pc_c        = 1'b0;
        ir_c        = 1'b0;
        case (state_q)
            SEQ_RUN: begin
                // A halt seen mid-instruction is remembered until WRITEBACK.
                halt_pend_d = halt_pend_q | halt_i;
                if (!stall_i) begin
                    if (at_fetch || (at_mem && mem_use_i)) begin
                        req_c      = 1'b1;
                        state_d    = SEQ_WAIT;
                        wcnt_d     = TIMEOUT_LOAD;
                        ack_held_d = 1'b0;
                    end else if (at_wb) begin
                        pc_c    = 1'b1;
                        stage_d = FETCH_ST;
                        if (halt_i || halt_pend_q) begin
                            state_d     = SEQ_HALTED;
                            halt_pend_d = 1'b0;
                        end
                    end else begin
                        stage_d = stage_adv;
                    end
                end
            end
            SEQ_WAIT: begin
                halt_pend_d = halt_pend_q | halt_i;
                req_c       = 1'b1;
                if (stall_i) begin
                    // Ack during a stall is held for when the stall lifts;
                    // the timeout keeps running (saturating at zero).
                    if (mem_ack_i) begin
                        ack_held_d = 1'b1;
                    end
                    if (wcnt_q != '0) begin
                        wcnt_d = wcnt_q - 1'b1;
                    end
                end else if (mem_ack_i || ack_held_q) begin
                    state_d    = SEQ_RUN;
                    stage_d    = stage_adv;
                    ack_held_d = 1'b0;
                    ir_c       = at_fetch;
                end else if (wcnt_q == '0) begin
                    state_d = SEQ_FAULT;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            SEQ_HALTED: begin
                halt_pend_d = 1'b0;
                if (resume_i && !halt_i) begin
                    state_d = SEQ_RUN;
                    stage_d = FETCH_ST;
                end
            end
            default: begin
            end
        endcase
    end

    assign stage_o     = stage_q;
    assign stage_en_o  = (state_q == SEQ_RUN || state_q == SEQ_WAIT)
                         ? (NSTAGES'(1) << stage_q) : '0;
    // Gated by reset so the request drops immediately, even in the issue cycle.
    assign mem_req_o   = req_c & ~reset;
    assign pc_readin_o = pc_c;
    assign retire_o    = pc_c;
    assign ir_load_o   = ir_c;
    assign instret_o   = instret_q;
    assign halted_o    = (state_q == SEQ_HALTED);
    assign fault_o     = (state_q == SEQ_FAULT);

endmodule

// File: tb/tb_stage_sequencer.sv
module tb_stage_sequencer;

    localparam int NST = 5;
    localparam int SW  = 3;
    localparam int CW  = 32;
    localparam int TMO = 15;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NST-1:0] skip_mask_i = '0;
    logic           mem_use_i = 1'b0;
    logic           mem_ack_i = 1'b0;
    logic           stall_i = 1'b0;
    logic           halt_i = 1'b0;
    logic           resume_i = 1'b0;
    logic [SW-1:0]  stage_o;
    logic [NST-1:0] stage_en_o;
    logic           mem_req_o;
    logic           pc_readin_o;
    logic           ir_load_o;
    logic           retire_o;
    logic [CW-1:0]  instret_o;
    logic           halted_o;
    logic           fault_o;

    stage_sequencer #(
        .NSTAGES (NST), .STAGE_W (SW), .FETCH_IDX (0), .MEM_IDX (3),
        .TIMEOUT (TMO), .CNT_W (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .skip_mask_i (skip_mask_i),
        .mem_use_i   (mem_use_i),
        .mem_ack_i   (mem_ack_i),
        .stall_i     (stall_i),
        .halt_i      (halt_i),
        .resume_i    (resume_i),
        .stage_o     (stage_o),
        .stage_en_o  (stage_en_o),
        .mem_req_o   (mem_req_o),
        .pc_readin_o (pc_readin_o),
        .ir_load_o   (ir_load_o),
        .retire_o    (retire_o),
        .instret_o   (instret_o),
        .halted_o    (halted_o),
        .fault_o     (fault_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Stimulus knobs. ack mode: 0 always, 1 after k_ack_delay wait cycles,
    // 2 random with k_ack_pct, 3 never.
    int             k_ack_mode, k_ack_delay, k_ack_pct;
    int             k_stall_pct, k_halt_pct, k_resume_pct;
    bit             k_halt_exec, k_mask_rand, k_memuse_rand;
    logic [NST-1:0] k_mask;
    bit             k_memuse;

    // Reference model: where the instruction is, plus a few flags.
    int        m_stage;
    bit        m_waiting;
    int        m_waited;
    bit        m_ack_held;
    bit        m_halted;
    bit        m_fault;
    bit        m_halt_req;
    logic [CW-1:0] m_instret;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_next(input int cur, input logic [NST-1:0] mask);
        int s;
        s = cur + 1;
        while (s >= 2 && s < NST - 1 && mask[s]) s++;
        return s;
    endfunction

    task automatic model_reset();
        m_stage = 0; m_waiting = 0; m_waited = 0; m_ack_held = 0;
        m_halted = 0; m_fault = 0; m_halt_req = 0; m_instret = '0;
    endtask

    // Predict this cycle's outputs from model state + applied inputs,
    // compare, then advance the model to the next cycle.
    task automatic model_cycle();
        logic [NST-1:0] e_en;
        bit e_req, e_pc, e_ir, needs_mem;
        int n_stage, n_waited;
        bit n_waiting, n_ack_held, n_halted, n_fault, n_halt_req;
        logic [CW-1:0] n_instret;
        e_en = (!m_halted && !m_fault) ? NST'(1 << m_stage) : '0;
        e_req = 0; e_pc = 0; e_ir = 0;
        n_stage = m_stage; n_waited = m_waited; n_waiting = m_waiting;
        n_ack_held = m_ack_held; n_halted = m_halted; n_fault = m_fault;
        n_halt_req = m_halt_req; n_instret = m_instret;
        if (m_fault) begin
        end else if (m_halted) begin
            n_halt_req = 0;
            if (resume_i && !halt_i) begin
                n_halted = 0;
                n_stage = 0;
            end
        end else begin
            n_halt_req = m_halt_req | halt_i;
            needs_mem = (m_stage == 0) || (m_stage == 3 && mem_use_i);
            if (m_waiting) begin
                e_req = 1;
                if (stall_i) begin
                    if (mem_ack_i) n_ack_held = 1;
                    n_waited = m_waited + 1;
                end else if (mem_ack_i || m_ack_held) begin
                    e_ir = (m_stage == 0);
                    n_waiting = 0;
                    n_ack_held = 0;
                    n_stage = model_next(m_stage, skip_mask_i);
                end else if (m_waited >= TMO - 1) begin
                    n_fault = 1;
                end else begin
                    n_waited = m_waited + 1;
                end
            end else if (stall_i) begin
            end else if (needs_mem) begin
                e_req = 1;
                n_waiting = 1;
                n_waited = 0;
                n_ack_held = 0;
            end else if (m_stage == NST - 1) begin
                e_pc = 1;
                n_instret = m_instret + 1;
                n_stage = 0;
                if (halt_i || m_halt_req) begin
                    n_halted = 1;
                    n_halt_req = 0;
                end
            end else begin
                n_stage = model_next(m_stage, skip_mask_i);
            end
        end
        check_val("stage",    32'(stage_o),     32'(m_stage));
        check_val("stage_en", 32'(stage_en_o),  32'(e_en));
        check_val("mem_req",  32'(mem_req_o),   32'(e_req));
        check_val("pc_readin",32'(pc_readin_o), 32'(e_pc));
        check_val("retire",   32'(retire_o),    32'(e_pc));
        check_val("ir_load",  32'(ir_load_o),   32'(e_ir));
        check_val("instret",  instret_o,        m_instret);
        check_val("halted",   32'(halted_o),    32'(m_halted));
        check_val("fault",    32'(fault_o),     32'(m_fault));
        m_stage = n_stage; m_waited = n_waited; m_waiting = n_waiting;
        m_ack_held = n_ack_held; m_halted = n_halted; m_fault = n_fault;
        m_halt_req = n_halt_req; m_instret = n_instret;
    endtask

    // Entered just after a falling edge; leaves at the next falling edge.
    task automatic run_cycle();
        skip_mask_i = k_mask_rand ? NST'($urandom_range(0, 31)) : k_mask;
        mem_use_i   = k_memuse_rand ? 1'($urandom_range(0, 1)) : k_memuse;
        case (k_ack_mode)
            0:       mem_ack_i = 1'b1;
            1:       mem_ack_i = m_waiting && (m_waited >= k_ack_delay);
            2:       mem_ack_i = ($urandom_range(0, 99) < k_ack_pct);
            default: mem_ack_i = 1'b0;
        endcase
        stall_i  = ($urandom_range(0, 99) < k_stall_pct);
        halt_i   = k_halt_exec ? (m_stage == 2 && !m_waiting && !m_halted)
                               : ($urandom_range(0, 99) < k_halt_pct);
        resume_i = ($urandom_range(0, 99) < k_resume_pct);
        #1;
        model_cycle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall_i = 0; halt_i = 0; resume_i = 0; mem_ack_i = 0;
        #1;
        check_val("rst_stage",   32'(stage_o),     0);
        check_val("rst_en",      32'(stage_en_o),  1);
        check_val("rst_req",     32'(mem_req_o),   0);
        check_val("rst_pc",      32'(pc_readin_o), 0);
        check_val("rst_ir",      32'(ir_load_o),   0);
        check_val("rst_retire",  32'(retire_o),    0);
        check_val("rst_instret", instret_o,        0);
        check_val("rst_halted",  32'(halted_o),    0);
        check_val("rst_fault",   32'(fault_o),     0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_knobs(input int ack_mode, input int ack_delay, input int ack_pct,
                             input int stall_pct, input int halt_pct, input int resume_pct,
                             input bit halt_exec, input bit mask_rand, input logic [NST-1:0] mask,
                             input bit memuse_rand, input bit memuse);
        k_ack_mode = ack_mode; k_ack_delay = ack_delay; k_ack_pct = ack_pct;
        k_stall_pct = stall_pct; k_halt_pct = halt_pct; k_resume_pct = resume_pct;
        k_halt_exec = halt_exec; k_mask_rand = mask_rand; k_mask = mask;
        k_memuse_rand = memuse_rand; k_memuse = memuse;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // No skips, zero-wait memory: 6-cycle instructions.
        set_knobs(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0);
        for (int i = 0; i < 60; i++) run_cycle();
        #1 check_val("instret_6cyc", instret_o, 10);
        do_reset();

        // EXEC and MEM skipped: 4-cycle instructions.
        set_knobs(0, 0, 0, 0, 0, 0, 0, 0, 5'b01100, 0, 0);
        for (int i = 0; i < 40; i++) run_cycle();
        #1 check_val("instret_4cyc", instret_o, 10);
        do_reset();

        // Memory in MEM stage, ack in third wait cycle.
        set_knobs(1, 2, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 1);
        for (int i = 0; i < 60; i++) run_cycle();

        // Halt pulsed in EXEC, deferred to WRITEBACK; resume at random.
        set_knobs(0, 0, 0, 0, 0, 25, 1, 0, 5'b00000, 1, 0);
        for (int i = 0; i < 80; i++) run_cycle();

        // Stalls with acks landing during the stall.
        set_knobs(2, 0, 50, 35, 0, 30, 0, 1, 5'b00000, 1, 0);
        for (int i = 0; i < 200; i++) run_cycle();
        do_reset();

        // Reset while a fetch request is outstanding.
        set_knobs(3, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0);
        for (int i = 0; i < 5; i++) run_cycle();
        #1 check_val("req_before_rst", 32'(mem_req_o), 1);
        do_reset();

        // Fetch never acknowledged: timeout fault, sticky until reset.
        for (int i = 0; i < 40; i++) run_cycle();
        #1;
        check_val("fault_sticky", 32'(fault_o), 1);
        check_val("fault_en",     32'(stage_en_o), 0);
        check_val("fault_req",    32'(mem_req_o), 0);
        do_reset();

        // Randomised mix with occasional resets.
        for (int i = 0; i < 2500; i++) begin
            if (i % 250 == 0) begin
                set_knobs($urandom_range(0, 2), $urandom_range(0, 5), $urandom_range(40, 90),
                          $urandom_range(0, 30), $urandom_range(0, 10), $urandom_range(5, 50),
                          1'($urandom_range(0, 1)), 1'b1, 5'b00000, 1'b1, 1'b0);
            end
            if ($urandom_range(0, 399) == 0) do_reset();
            else run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
